pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage core. Drives the `en` (active-high hold-when-low) and `clr` (active-low bubble-insert) inputs of all four stage registers, IF/ID, ID/EX, EX/DM and DM/WB, plus the PC enable. It also sequences syscall-halt draining and multi-cycle data-memory waits, and keeps cycle, stall and flush performance counters. It sits beside the datapath in the core top level. It consumes hazard information from the ID, EX, DM and WB stages.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_ctrl_if.sv | 53 +++++
 rtl/pipe_hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encodings for the pipeline stall/flush controller
package pipeline_ctrl_pkg;

  // Width of the controller state register.
  localparam int PC_ST_BIT = 2;

  // Controller states; RUN is the reset state.
  typedef enum logic [PC_ST_BIT-1:0] {
    PC_ST_RUN      = 2'd0,
    PC_ST_MEM_WAIT = 2'd1,
    PC_ST_DRAIN    = 2'd2,
    PC_ST_HALTED   = 2'd3
  } pc_state_e;

  // Register number that never carries a real dependency.
  localparam logic [4:0] PC_REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage control outputs of the pipeline controller
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       id_req_a;
  logic [4:0]       id_req_b;
  logic             id_use_a;
  logic             id_use_b;
  logic             id_jump;
  logic             ex_mem_read;
  logic [4:0]       ex_req_w;
  logic             ex_branch_taken;
  logic             ex_halt;
  logic             wb_halt;
  logic             dm_busy;
  logic             resume;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_dm_en;
  logic             dm_wb_en;
  logic             if_id_clr;
  logic             id_ex_clr;
  logic             ex_dm_clr;
  logic             dm_wb_clr;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Datapath side: supplies hazard information, consumes the controls.
  modport master (
    output id_req_a, id_req_b, id_use_a, id_use_b, id_jump,
    output ex_mem_read, ex_req_w, ex_branch_taken, ex_halt,
    output wb_halt, dm_busy, resume,
    input  pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
    input  if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr,
    input  halted, cycle_cnt, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_req_a, id_req_b, id_use_a, id_use_b, id_jump,
    input  ex_mem_read, ex_req_w, ex_branch_taken, ex_halt,
    input  wb_halt, dm_busy, resume,
    output pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
    output if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr,
    output halted, cycle_cnt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - load-use hazard compare between ID sources and EX load destination
module pipe_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_req_w_i,
  input  logic [4:0] id_req_a_i,
  input  logic [4:0] id_req_b_i,
  input  logic       id_use_a_i,
  input  logic       id_use_b_i,
  output logic       lu_o
);

  logic hit_a;
  logic hit_b;

  // A source only matters if the ID instruction actually reads it.
  assign hit_a = id_use_a_i && (id_req_a_i == ex_req_w_i);
  assign hit_b = id_use_b_i && (id_req_b_i == ex_req_w_i);

  // Loads into r0 never create a dependency.
  assign lu_o = ex_mem_read_i && (ex_req_w_i != PC_REG_ZERO) && (hit_a || hit_b);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/halt sequencer and performance counters for the 5-stage core
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  pc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic stall_evt;
  logic flush_evt;

  logic pc_en;
  logic if_id_en, id_ex_en, ex_dm_en, dm_wb_en;
  logic if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr;
  logic halted;

  pipe_hazard_detect u_hazard (
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_req_w_i    (bus.ex_req_w),
    .id_req_a_i    (bus.id_req_a),
    .id_req_b_i    (bus.id_req_b),
    .id_use_a_i    (bus.id_use_a),
    .id_use_b_i    (bus.id_use_b),
    .lu_o          (lu)
  );

  // Output decode and next state: controls are combinational so they act on this edge.
  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    id_ex_en  = 1'b1;
    ex_dm_en  = 1'b1;
    dm_wb_en  = 1'b1;
    if_id_clr = 1'b1;
    id_ex_clr = 1'b1;
    ex_dm_clr = 1'b1;
    dm_wb_clr = 1'b1;
    halted    = 1'b0;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    state_d   = state_q;

    case (state_q)
      // MEM_WAIT with memory ready behaves exactly like RUN.
      PC_ST_RUN, PC_ST_MEM_WAIT: begin
        if (bus.dm_busy) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_dm_en  = 1'b0;
          dm_wb_en  = 1'b0;
          dm_wb_clr = 1'b0;
          stall_evt = 1'b1;
          state_d   = PC_ST_MEM_WAIT;
        end else if (bus.ex_halt) begin
          pc_en     = 1'b0;
          if_id_clr = 1'b0;
          id_ex_clr = 1'b0;
          state_d   = PC_ST_DRAIN;
        end else begin
          state_d = PC_ST_RUN;
          if (bus.ex_branch_taken) begin
            // PC stays enabled so it picks up the branch target.
            if_id_clr = 1'b0;
            id_ex_clr = 1'b0;
            flush_evt = 1'b1;
          end else if (lu) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b0;
            stall_evt = 1'b1;
          end else if (bus.id_jump) begin
            if_id_clr = 1'b0;
            flush_evt = 1'b1;
          end
        end
      end

      // Let the halt ride to WB while nothing new enters the front end.
      PC_ST_DRAIN: begin
        pc_en     = 1'b0;
        if_id_clr = 1'b0;
        id_ex_clr = 1'b0;
        if (bus.dm_busy) begin
          ex_dm_en  = 1'b0;
          dm_wb_clr = 1'b0;
          stall_evt = 1'b1;
        end
        if (bus.wb_halt) begin
          state_d = PC_ST_HALTED;
        end
      end

      PC_ST_HALTED: begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
        ex_dm_en = 1'b0;
        dm_wb_en = 1'b0;
        halted   = 1'b1;
        if (bus.resume) begin
          // Bubble WB so the halt instruction is not seen again.
          dm_wb_clr = 1'b0;
          state_d   = PC_ST_RUN;
        end
      end

      default: state_d = PC_ST_RUN;
    endcase
  end

  // Counter next values; all wrap naturally.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != PC_ST_HALTED) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
    if (stall_evt) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_evt) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PC_ST_RUN;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.if_id_en  = if_id_en;
  assign bus.id_ex_en  = id_ex_en;
  assign bus.ex_dm_en  = ex_dm_en;
  assign bus.dm_wb_en  = dm_wb_en;
  assign bus.if_id_clr = if_id_clr;
  assign bus.id_ex_clr = id_ex_clr;
  assign bus.ex_dm_clr = ex_dm_clr;
  assign bus.dm_wb_clr = dm_wb_clr;
  assign bus.halted    = halted;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  logic [8:0] ctl;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en, if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr}
  always_comb ctl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_dm_en, bus.dm_wb_en,
                     bus.if_id_clr, bus.id_ex_clr, bus.ex_dm_clr, bus.dm_wb_clr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle();
    bus.id_req_a        = 5'd0;
    bus.id_req_b        = 5'd0;
    bus.id_use_a        = 1'b0;
    bus.id_use_b        = 1'b0;
    bus.id_jump         = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_req_w        = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_halt         = 1'b0;
    bus.wb_halt         = 1'b0;
    bus.dm_busy         = 1'b0;
    bus.resume          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu_a(input logic [4:0] r);
    bus.ex_mem_read = 1'b1;
    bus.ex_req_w    = r;
    bus.id_use_a    = 1'b1;
    bus.id_req_a    = r;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cyc"}, bus.cycle_cnt, 32'd0);
    check({tag, "_stall"}, bus.stall_cnt, 32'd0);
    check({tag, "_flush"}, bus.flush_cnt, 32'd0);
    check({tag, "_ctl"}, {23'd0, ctl}, 32'h1FF);
    check({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_cleared("reset");

    // load-use through source A
    set_lu_a(5'd3);
    #1 check("lu_a_ctl", {23'd0, ctl}, 32'h07B);
    tick();                                         // cycle 1
    check("lu_a_stall", bus.stall_cnt, 32'd1);
    idle();
    #1 check("lu_a_after", {23'd0, ctl}, 32'h1FF);

    // load into r0 never stalls
    set_lu_a(5'd0);
    #1 check("lu_r0_ctl", {23'd0, ctl}, 32'h1FF);
    tick();                                         // cycle 2
    check("lu_r0_stall", bus.stall_cnt, 32'd1);
    idle();

    // load-use through source B
    bus.ex_mem_read = 1'b1;
    bus.ex_req_w    = 5'd7;
    bus.id_req_b    = 5'd7;
    bus.id_use_b    = 1'b0;
    #1 check("lu_b_unused", {23'd0, ctl}, 32'h1FF);
    bus.id_use_b    = 1'b1;
    #1 check("lu_b_ctl", {23'd0, ctl}, 32'h07B);
    tick();                                         // cycle 3
    check("lu_b_stall", bus.stall_cnt, 32'd2);
    idle();

    // branch beats load-use
    bus.ex_branch_taken = 1'b1;
    set_lu_a(5'd5);
    #1 check("br_lu_ctl", {23'd0, ctl}, 32'h1F3);
    tick();                                         // cycle 4
    check("br_lu_flush", bus.flush_cnt, 32'd1);
    check("br_lu_stall", bus.stall_cnt, 32'd2);
    idle();

    // memory wait for three cycles with a jump pending in ID
    bus.dm_busy = 1'b1;
    bus.id_jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("busy%0d_ctl", i), {23'd0, ctl}, 32'h00E);
      tick();                                       // cycles 5..7
    end
    check("busy_stall", bus.stall_cnt, 32'd5);
    check("busy_flush", bus.flush_cnt, 32'd1);
    bus.dm_busy = 1'b0;
    #1 check("jump_ctl", {23'd0, ctl}, 32'h1F7);
    tick();                                         // cycle 8
    check("jump_flush", bus.flush_cnt, 32'd2);
    check("jump_stall", bus.stall_cnt, 32'd5);
    check("jump_cyc", bus.cycle_cnt, 32'd8);
    idle();

    // halt drain and resume
    bus.ex_halt = 1'b1;
    #1 check("halt_ctl", {23'd0, ctl}, 32'h0F3);
    tick();                                         // cycle 9, DRAIN
    bus.ex_halt         = 1'b0;
    bus.ex_branch_taken = 1'b1;
    bus.id_jump         = 1'b1;
    set_lu_a(5'd4);
    #1 check("drain_ctl", {23'd0, ctl}, 32'h0F3);
    check("drain_halted", {31'd0, bus.halted}, 32'd0);
    tick();                                         // cycle 10
    idle();
    bus.wb_halt = 1'b1;
    #1 check("drain_wb_ctl", {23'd0, ctl}, 32'h0F3);
    tick();                                         // cycle 11, HALTED
    bus.wb_halt = 1'b0;
    #1 check("halted_flag", {31'd0, bus.halted}, 32'd1);
    check("halted_ctl", {23'd0, ctl}, 32'h00F);
    check("halted_flush", bus.flush_cnt, 32'd2);
    tick();
    tick();
    check("halted_cyc", bus.cycle_cnt, 32'd11);
    bus.resume = 1'b1;
    #1 check("resume_ctl", {23'd0, ctl}, 32'h00E);
    check("resume_halted", {31'd0, bus.halted}, 32'd1);
    tick();
    bus.resume = 1'b0;
    #1 check("run_halted", {31'd0, bus.halted}, 32'd0);
    check("run_ctl", {23'd0, ctl}, 32'h1FF);
    check("run_cyc", bus.cycle_cnt, 32'd11);
    tick();                                         // cycle 12

    // stray wb_halt and resume are ignored in RUN
    bus.wb_halt = 1'b1;
    #1 check("wbh_run_ctl", {23'd0, ctl}, 32'h1FF);
    tick();                                         // cycle 13
    bus.wb_halt = 1'b0;
    bus.resume  = 1'b1;
    #1 check("res_run_halted", {31'd0, bus.halted}, 32'd0);
    check("res_run_ctl", {23'd0, ctl}, 32'h1FF);
    bus.resume = 1'b0;
    check("stray_cyc", bus.cycle_cnt, 32'd13);

    // memory wait inside DRAIN, then reset from DRAIN
    bus.ex_halt = 1'b1;
    tick();                                         // cycle 14, DRAIN
    bus.ex_halt = 1'b0;
    bus.dm_busy = 1'b1;
    #1 check("drain_busy_ctl", {23'd0, ctl}, 32'h0D2);
    tick();                                         // cycle 15
    check("drain_busy_stall", bus.stall_cnt, 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dm_busy = 1'b0;
    #1 check_cleared("rst_drain");

    // reach HALTED with cycle_cnt = 50, then reset
    repeat (47) tick();                             // cycle 47
    bus.ex_halt = 1'b1;
    tick();                                         // cycle 48
    bus.ex_halt = 1'b0;
    tick();                                         // cycle 49
    bus.wb_halt = 1'b1;
    tick();                                         // cycle 50, HALTED
    bus.wb_halt = 1'b0;
    #1 check("h50_halted", {31'd0, bus.halted}, 32'd1);
    check("h50_cyc", bus.cycle_cnt, 32'd50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check_cleared("rst_halted");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
